// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared encodings and constants for the HI/LO multiply/divide unit
package mdu_pkg;

   localparam logic [1:0] MDU_MULT  = 2'd0;
   localparam logic [1:0] MDU_MULTU = 2'd1;
   localparam logic [1:0] MDU_DIV   = 2'd2;
   localparam logic [1:0] MDU_DIVU  = 2'd3;

   localparam int MDU_ITERS = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      SIGN = 2'd2
   } mdu_state_e;

endpackage

// File: rtl/abs_neg32.sv
// rtl/abs_neg32.sv - conditional 32-bit two's-complement negation
module abs_neg32 (
   input  logic        neg,
   input  logic [31:0] a,
   output logic [31:0] y
);

   assign y = neg ? (~a + 32'd1) : a;

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit owning HI and LO
module mult_div_unit
   import mdu_pkg::*;
(
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic        Start,
   input  logic [1:0]  Op,
   input  logic [31:0] OperandA,
   input  logic [31:0] OperandB,
   input  logic        WriteHi,
   input  logic        WriteLo,
   input  logic [31:0] WriteData,
   output logic        Busy,
   output logic        Done,
   output logic [31:0] Hi,
   output logic [31:0] Lo
);

   mdu_state_e  state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [63:0] acc_q, acc_d;
   logic [31:0] b_q, b_d;
   logic        sa_q, sa_d;
   logic        sb_q, sb_d;
   logic        div_q, div_d;
   logic        done_q, done_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   // Op[0] clear selects the signed flavours (MULT, DIV); Op[1] selects divide.
   logic        op_signed;
   logic        a_neg, b_neg;
   logic [31:0] a_mag, b_mag;
   logic [31:0] quo_fix, rem_fix;
   logic [63:0] prod_fix;

   assign op_signed = ~Op[0];
   assign a_neg     = op_signed & OperandA[31];
   assign b_neg     = op_signed & OperandB[31];

   abs_neg32 u_abs_a (.neg(a_neg), .a(OperandA), .y(a_mag));
   abs_neg32 u_abs_b (.neg(b_neg), .a(OperandB), .y(b_mag));

   // Quotient sign follows sA^sB, remainder sign follows the dividend.
   abs_neg32 u_fix_q (.neg(sa_q ^ sb_q), .a(acc_q[31:0]),  .y(quo_fix));
   abs_neg32 u_fix_r (.neg(sa_q),        .a(acc_q[63:32]), .y(rem_fix));

   assign prod_fix = (sa_q ^ sb_q) ? (~acc_q + 64'd1) : acc_q;

   // Multiply step: conditional add into the upper half, then shift the 65-bit result right.
   logic [32:0] mul_sum;
   logic [63:0] mul_next;

   assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
   assign mul_next = {mul_sum, acc_q[31:1]};

   // Divide step: acc holds {remainder, dividend/quotient}; shift one dividend bit in, trial subtract.
   logic [32:0] rem_sh;
   logic [32:0] div_diff;
   logic        div_ge;
   logic [63:0] div_next;

   assign rem_sh   = {acc_q[63:32], acc_q[31]};
   assign div_diff = rem_sh - {1'b0, b_q};
   assign div_ge   = (rem_sh >= {1'b0, b_q});
   assign div_next = {(div_ge ? div_diff[31:0] : rem_sh[31:0]), acc_q[30:0], div_ge};

   // Next-state, datapath and HI/LO update logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      b_d     = b_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      div_d   = div_q;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         IDLE: begin
            if (WriteHi) hi_d = WriteData;
            if (WriteLo) lo_d = WriteData;
            if (Start) begin
               state_d = RUN;
               cnt_d   = 5'(MDU_ITERS - 1);
               acc_d   = {32'd0, a_mag};
               b_d     = b_mag;
               sa_d    = a_neg;
               sb_d    = b_neg;
               div_d   = Op[1];
            end
         end
         RUN: begin
            acc_d = div_q ? div_next : mul_next;
            if (cnt_q == 5'd0) begin
               state_d = SIGN;
            end else begin
               cnt_d = cnt_q - 5'd1;
            end
         end
         SIGN: begin
            state_d = IDLE;
            done_d  = 1'b1;
            if (div_q) begin
               if (b_q == 32'd0) begin
                  // Divide by zero: all-ones quotient, remainder is the latched dividend unfixed.
                  lo_d = 32'hFFFF_FFFF;
                  hi_d = acc_q[63:32];
               end else begin
                  lo_d = quo_fix;
                  hi_d = rem_fix;
               end
            end else begin
               hi_d = prod_fix[63:32];
               lo_d = prod_fix[31:0];
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous clear.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 5'd0;
         acc_q   <= 64'd0;
         b_q     <= 32'd0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         div_q   <= 1'b0;
         done_q  <= 1'b0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         b_q     <= b_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         div_q   <= div_d;
         done_q  <= done_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign Busy = (state_q != IDLE);
   assign Done = done_q;
   assign Hi   = hi_q;
   assign Lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit
module tb_mult_div_unit;

   logic        Clk = 1'b0;
   logic        Rst_n = 1'b0;
   logic        Start = 1'b0;
   logic [1:0]  Op = 2'd0;
   logic [31:0] OperandA = 32'd0;
   logic [31:0] OperandB = 32'd0;
   logic        WriteHi = 1'b0;
   logic        WriteLo = 1'b0;
   logic [31:0] WriteData = 32'd0;
   logic        Busy;
   logic        Done;
   logic [31:0] Hi;
   logic [31:0] Lo;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_hi = 32'd0;
   logic [31:0] exp_lo = 32'd0;
   logic [31:0] pend_hi = 32'd0;
   logic [31:0] pend_lo = 32'd0;

   always #5 Clk = ~Clk;

   mult_div_unit dut (
      .Clk       (Clk),
      .Rst_n     (Rst_n),
      .Start     (Start),
      .Op        (Op),
      .OperandA  (OperandA),
      .OperandB  (OperandB),
      .WriteHi   (WriteHi),
      .WriteLo   (WriteLo),
      .WriteData (WriteData),
      .Busy      (Busy),
      .Done      (Done),
      .Hi        (Hi),
      .Lo        (Lo)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Architectural reference: {HI, LO} from plain 64-bit arithmetic.
   function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      longint      x, y, q, rm;
      logic [31:0] amag;
      logic [63:0] r;
      x    = longint'($signed(a));
      y    = longint'($signed(b));
      amag = a[31] ? (~a + 32'd1) : a;
      r    = 64'd0;
      case (op)
         2'd0: r = 64'(x * y);
         2'd1: r = {32'd0, a} * {32'd0, b};
         2'd2: begin
            if (b == 32'd0) r = {amag, 32'hFFFF_FFFF};
            else begin
               q  = x / y;
               rm = x % y;
               r  = {rm[31:0], q[31:0]};
            end
         end
         default: begin
            if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
            else r = {a % b, a / b};
         end
      endcase
      return r;
   endfunction

   // Called just after a negedge; returns just after the negedge following E0.
   task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo);
      Start    = 1'b1;
      Op       = op;
      OperandA = a;
      OperandB = b;
      @(negedge Clk);
      Start    = 1'b0;
      WriteHi  = 1'b0;
      WriteLo  = 1'b0;
      OperandA = $urandom;
      OperandB = $urandom;
      Op       = 2'($urandom);
      pend_hi  = ehi;
      pend_lo  = elo;
   endtask

   // Waits for Done, k0 cycles already elapsed after E0, then checks timing and result.
   task automatic finish(input int k0, input string tag);
      int lat;
      int busy_cycles;
      lat = k0;
      busy_cycles = k0;
      while (!Done && lat < 40) begin
         if (Busy) busy_cycles++;
         if (lat == 16) begin
            chk({tag, "_hold_hi"}, Hi, exp_hi);
            chk({tag, "_hold_lo"}, Lo, exp_lo);
         end
         @(negedge Clk);
         lat++;
      end
      chk({tag, "_latency"}, 32'(lat), 32'd33);
      chk({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd33);
      chk({tag, "_busy_in_done"}, 32'(Busy), 32'd0);
      exp_hi = pend_hi;
      exp_lo = pend_lo;
      chk({tag, "_hi"}, Hi, exp_hi);
      chk({tag, "_lo"}, Lo, exp_lo);
   endtask

   initial begin
      logic [63:0] m;
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      int          pulses;

      // Reset state
      #2;
      chk("rst_busy", 32'(Busy), 32'd0);
      chk("rst_done", 32'(Done), 32'd0);
      chk("rst_hi", Hi, 32'd0);
      chk("rst_lo", Lo, 32'd0);
      @(negedge Clk);
      @(negedge Clk);
      Rst_n = 1'b1;
      @(negedge Clk);

      // Directed multiplies
      launch(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      finish(0, "multu_max");
      @(negedge Clk);
      launch(2'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      finish(0, "mult_neg");
      @(negedge Clk);
      launch(2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
      finish(0, "mult_min");

      // Back-to-back divides: second Start lands in the Done cycle
      @(negedge Clk);
      launch(2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      finish(0, "div_neg");
      launch(2'd3, 32'd100, 32'd7, 32'd2, 32'd14);
      finish(0, "divu_b2b");

      // Overflow and divide-by-zero corners
      launch(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
      finish(0, "div_ovf");
      @(negedge Clk);
      launch(2'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
      finish(0, "divu_zero");

      // MTHI in IDLE
      @(negedge Clk);
      WriteHi   = 1'b1;
      WriteData = 32'h0000_1234;
      @(negedge Clk);
      WriteHi   = 1'b0;
      chk("mthi_hi", Hi, 32'h0000_1234);
      chk("mthi_lo", Lo, exp_lo);
      exp_hi = 32'h0000_1234;

      // MTLO coinciding with Start: write lands, result overwrites later
      WriteLo   = 1'b1;
      WriteData = 32'h0000_CAFE;
      launch(2'd1, 32'd3, 32'd4, 32'd0, 32'd12);
      chk("mtlo_start_lo", Lo, 32'h0000_CAFE);
      exp_lo = 32'h0000_CAFE;
      finish(0, "mtlo_start");

      // MTLO and Start while running are ignored
      @(negedge Clk);
      m = model(2'd1, 32'h1234_5678, 32'h9ABC_DEF0);
      launch(2'd1, 32'h1234_5678, 32'h9ABC_DEF0, m[63:32], m[31:0]);
      repeat (5) @(negedge Clk);
      WriteLo   = 1'b1;
      WriteData = 32'h0000_DEAD;
      Start     = 1'b1;
      Op        = 2'd3;
      OperandA  = 32'd9;
      OperandB  = 32'd2;
      @(negedge Clk);
      WriteLo   = 1'b0;
      Start     = 1'b0;
      chk("run_write_lo", Lo, exp_lo);
      chk("run_write_hi", Hi, exp_hi);
      finish(6, "run_ignore");
      repeat (3) @(negedge Clk);
      chk("run_no_second_op", 32'(Busy), 32'd0);

      // Asynchronous reset ten cycles into a MULT
      launch(2'd0, 32'hFFFF_FF00, 32'd77, 32'd0, 32'd0);
      repeat (10) @(negedge Clk);
      Rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(Busy), 32'd0);
      chk("arst_done", 32'(Done), 32'd0);
      chk("arst_hi", Hi, 32'd0);
      chk("arst_lo", Lo, 32'd0);
      exp_hi = 32'd0;
      exp_lo = 32'd0;
      @(negedge Clk);
      Rst_n = 1'b1;
      pulses = 0;
      repeat (40) begin
         @(negedge Clk);
         if (Done) pulses++;
      end
      chk("arst_no_done", 32'(pulses), 32'd0);
      m = model(2'd0, 32'hFFFF_FF00, 32'd77);
      launch(2'd0, 32'hFFFF_FF00, 32'd77, m[63:32], m[31:0]);
      finish(0, "arst_after");

      // Randomized operations against the reference model
      for (int i = 0; i < 24; i++) begin
         rop = 2'($urandom);
         ra  = $urandom;
         rb  = $urandom;
         case ($urandom_range(0, 5))
            0: rb = $urandom_range(0, 15);
            1: ra = $urandom_range(0, 1) ? 32'h8000_0000 : 32'hFFFF_FFFF;
            2: rb = $urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'd0;
            default: ;
         endcase
         m = model(rop, ra, rb);
         if ($urandom_range(0, 1) == 1) @(negedge Clk);
         launch(rop, ra, rb, m[63:32], m[31:0]);
         finish(0, $sformatf("rand%0d_op%0d", i, rop));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
